rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 32-entry register file. It shares the single RF write port (RFWr/A3/WD) between two write-back requesters, for example the ALU path and the slow load/multiply path. Arbitration is round-robin with a valid/ready handshake, and each winning write is registered for one cycle before it drives the port. A 32-bit pending-write scoreboard lets decode stall on RAW hazards against writes that are still in flight.

---
 rtl/rf_wb_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the single RF write port, with a registered output stage
// and a pending-write scoreboard for RAW hazard checks. Optional stall counters: RF_WB_STATS_EN.
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AW-1:0]     req0_addr,
  input  logic [DW-1:0]     req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AW-1:0]     req1_addr,
  input  logic [DW-1:0]     req1_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [AW-1:0]     chk_addr1,
  input  logic [AW-1:0]     chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [(1<<AW)-1:0] pending
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0]       stall0_cnt,
  output logic [15:0]       stall1_cnt
`endif
);

  localparam int NREG = 1 << AW;

  logic            prio_q, prio_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            grant0, grant1;

  // prio names the requester that wins when both are valid
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d     = prio_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant0) begin
      prio_d     = 1'b1;
      rf_we_d    = (req0_addr != '0);
      rf_waddr_d = req0_addr;
      rf_wdata_d = req0_data;
    end else if (grant1) begin
      prio_d     = 1'b0;
      rf_we_d    = (req1_addr != '0);
      rf_waddr_d = req1_addr;
      rf_wdata_d = req1_data;
    end
  end

  // Clear first so a same-edge reserve of the register being written keeps it pending
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      pending_d[rsv_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      prio_q     <= prio_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign chk_busy1  = pending_q[chk_addr1];
  assign chk_busy2  = pending_q[chk_addr2];
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pending    = pending_q;

`ifdef RF_WB_STATS_EN
  logic [1:0][15:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       stalled;

  assign stalled = {req1_valid && !grant1, req0_valid && !grant0};

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (stalled[k] && (stall_cnt_q[k] != 16'hFFFF)) begin
        stall_cnt_d[k] = stall_cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall0_cnt = stall_cnt_q[0];
  assign stall1_cnt = stall_cnt_q[1];
`endif

endmodule
